// File: rtl/uart_sample_scheduler_if.sv
// Byte-transmit handshake between the sample scheduler and the shared uart_tx.
// The master pulses tx_start for one cycle with tx_data valid; the slave raises tx_busy while shifting.
interface uart_sample_scheduler_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/uart_sample_scheduler.sv
// Decimates the CODEC sample strobe, snapshots four channels and streams one
// 'C','H','0'+ch,MSB,LSB frame per enabled channel to uart_tx; drops and counts late snapshots.
module uart_sample_scheduler #(
    parameter int W        = 16,
    parameter int DECIMATE = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_clk,
    input  logic [3:0]              ch_mask,
    input  logic [W-1:0]            sample_in0,
    input  logic [W-1:0]            sample_in1,
    input  logic [W-1:0]            sample_in2,
    input  logic [W-1:0]            sample_in3,
    uart_sample_scheduler_if.master tx,
    output logic                    burst_active,
    output logic                    frame_done,
    output logic [7:0]              overrun_cnt,
    output logic [2:0]              fsm_state
);

    if (W != 16) begin : g_bad_width
        $error("uart_sample_scheduler: W must be 16");
    end

    localparam int DEC_W = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIMATE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           state;
    logic             sc_q;
    logic             sc_edge;
    logic [DEC_W-1:0] dec_cnt;
    logic             snap_req;
    logic [W-1:0]     snap [4];
    logic [3:0]       snap_mask;
    logic [2:0]       ptr;
    logic [1:0]       ch;
    logic [2:0]       idx;
    logic             sel_found;
    logic [1:0]       sel_ch;
    logic [W-1:0]     cur_sample;
    logic [7:0]       cur_byte;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;

    assign sc_edge   = sample_clk & ~sc_q;
    assign snap_req  = sc_edge && (dec_cnt == DEC_LAST);
    assign fsm_state = state;
    assign tx.tx_start = tx_start_q;
    assign tx.tx_data  = tx_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q    <= 1'b0;
            dec_cnt <= '0;
        end else begin
            sc_q <= sample_clk;
            if (sc_edge) begin
                dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
            end
        end
    end

    // Lowest latched-enabled channel at or above the pointer; descending scan leaves the lowest.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (snap_mask[i] && (3'(i) >= ptr)) begin
                sel_found = 1'b1;
                sel_ch    = 2'(i);
            end
        end
    end

    always_comb begin
        cur_sample = snap[ch];
        case (idx)
            3'd0:    cur_byte = 8'h43;
            3'd1:    cur_byte = 8'h48;
            3'd2:    cur_byte = 8'h30 + {6'd0, ch};
            3'd3:    cur_byte = cur_sample[15:8];
            default: cur_byte = cur_sample[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            burst_active <= 1'b0;
            frame_done   <= 1'b0;
            overrun_cnt  <= 8'h00;
            snap_mask    <= 4'h0;
            ptr          <= 3'd0;
            ch           <= 2'd0;
            idx          <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                snap[i] <= '0;
            end
        end else begin
            tx_start_q <= 1'b0;
            frame_done <= 1'b0;
            // Any request outside IDLE (including DONE) is a dropped snapshot.
            if (snap_req && (state != S_IDLE) && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (snap_req && (ch_mask != 4'h0)) begin
                        snap[0]      <= sample_in0;
                        snap[1]      <= sample_in1;
                        snap[2]      <= sample_in2;
                        snap[3]      <= sample_in3;
                        snap_mask    <= ch_mask;
                        ptr          <= 3'd0;
                        burst_active <= 1'b1;
                        state        <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (sel_found) begin
                        ch    <= sel_ch;
                        idx   <= 3'd0;
                        state <= S_SEND;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_SEND: begin
                    if (!tx.tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= cur_byte;
                        state      <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (tx.tx_busy) begin
                        state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx.tx_busy) begin
                        if (idx == 3'd4) begin
                            ptr   <= {1'b0, ch} + 3'd1;
                            state <= S_SELECT;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= S_SEND;
                        end
                    end
                end
                S_DONE: begin
                    frame_done   <= 1'b1;
                    burst_active <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sample_scheduler.sv
// Randomised bench for uart_sample_scheduler: a byte-queue model of the frame stream,
// a timed uart_tx responder, and literal frame checks for the directed scenarios.
module tb_uart_sample_scheduler;
  localparam int DEC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_clk;
  logic [3:0]  ch_mask;
  logic [15:0] s0, s1, s2, s3;
  logic        burst_active, frame_done;
  logic [7:0]  overrun_cnt;
  logic [2:0]  fsm_state;

  uart_sample_scheduler_if tx_if ();

  uart_sample_scheduler #(.W(16), .DECIMATE(DEC)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .ch_mask(ch_mask),
    .sample_in0(s0), .sample_in1(s1), .sample_in2(s2), .sample_in3(s3),
    .tx(tx_if), .burst_active(burst_active), .frame_done(frame_done),
    .overrun_cnt(overrun_cnt), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // stimulus knobs applied at the next step
  logic        d_sc;
  logic [3:0]  d_mask;
  logic [15:0] d_s [4];
  int          hold_lo, hold_hi;

  // behavioural model / scoreboard
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  bit         m_active;
  int         done_cd;
  int         dec_m;
  bit         prev_sc;
  int         exp_ovr;
  logic [7:0] exp_txd;
  bit         prev_start;
  int         busy_left;
  int         fd_cnt, start_cnt;
  int         n_cmp, n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_active   = 0;
    done_cd    = 0;
    dec_m      = 0;
    prev_sc    = 0;
    exp_ovr    = 0;
    exp_txd    = 8'h00;
    prev_start = 0;
    busy_left  = 0;
    tx_if.tx_busy = 1'b0;
    d_sc       = 1'b0;
    sample_clk = 1'b0;
  endtask

  // One clock: check outputs, run the uart responder, apply the next inputs.
  task automatic step();
    bit exp_fd;
    @(negedge clk);
    exp_fd = 0;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) begin
        exp_fd   = 1;
        m_active = 0;
      end
    end
    chk("burst_active", burst_active, m_active);
    chk("frame_done", frame_done, exp_fd);
    chk("overrun_cnt", overrun_cnt, exp_ovr);
    if (frame_done === 1'b1) fd_cnt++;
    if (tx_if.tx_start === 1'b1) begin
      start_cnt++;
      chk("tx_start_gap", prev_start, 0);
      if (exp_q.size() == 0) begin
        chk("tx_start_unexpected", tx_if.tx_start, 0);
      end else begin
        exp_txd = exp_q.pop_front();
        chk("tx_data", tx_if.tx_data, exp_txd);
      end
      got_q.push_back(tx_if.tx_data);
      busy_left     = $urandom_range(hold_hi, hold_lo);
      tx_if.tx_busy = 1'b1;
    end else begin
      chk("tx_start", tx_if.tx_start, 0);
      chk("tx_data_hold", tx_if.tx_data, exp_txd);
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          tx_if.tx_busy = 1'b0;
          if (m_active && exp_q.size() == 0) done_cd = 3;
        end
      end
    end
    prev_start = (tx_if.tx_start === 1'b1);
    sample_clk = d_sc;
    ch_mask    = d_mask;
    s0 = d_s[0]; s1 = d_s[1]; s2 = d_s[2]; s3 = d_s[3];
    if (d_sc && !prev_sc) begin
      dec_m++;
      if (dec_m == DEC) begin
        dec_m = 0;
        if (m_active) begin
          if (exp_ovr < 255) exp_ovr++;
        end else if (d_mask != 4'h0) begin
          m_active = 1;
          for (int c = 0; c < 4; c++) begin
            if (d_mask[c]) begin
              exp_q.push_back(8'h43);
              exp_q.push_back(8'h48);
              exp_q.push_back(8'h30 + 8'(c));
              exp_q.push_back(d_s[c][15:8]);
              exp_q.push_back(d_s[c][7:0]);
            end
          end
        end
      end
    end
    prev_sc = d_sc;
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      d_sc = 1'b1; step();
      d_sc = 1'b0; step();
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((m_active || done_cd > 0) && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (m_active) begin
      n_bad++;
      $display("FAIL idle_timeout: burst still active after %0d cycles", budget);
    end
    repeat (2) step();
  endtask

  task automatic chk_bytes(input string name, input logic [159:0] lit, input int n);
    chk({name, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      chk(name, got_q[i], lit[(n-1-i)*8 +: 8]);
    end
  endtask

  task automatic zero_outputs(input string name);
    chk({name, "_tx_start"}, tx_if.tx_start, 0);
    chk({name, "_tx_data"}, tx_if.tx_data, 0);
    chk({name, "_burst_active"}, burst_active, 0);
    chk({name, "_frame_done"}, frame_done, 0);
    chk({name, "_overrun"}, overrun_cnt, 0);
  endtask

  // Called just after a negedge: asynchronous reset must clear outputs without a clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 zero_outputs("async_rst");
    model_reset();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic set_samples(input logic [15:0] a, b, c, d);
    d_s[0] = a; d_s[1] = b; d_s[2] = c; d_s[3] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_cmp = 0; n_bad = 0; fd_cnt = 0; start_cnt = 0;
    rst = 1'b1;
    ch_mask = 4'h0; s0 = '0; s1 = '0; s2 = '0; s3 = '0;
    d_mask = 4'h0; set_samples(16'h0, 16'h0, 16'h0, 16'h0);
    hold_lo = 2; hold_hi = 2;
    model_reset();
    #1 zero_outputs("reset");
    repeat (2) step();
    rst = 1'b0;

    // all channels, fixed samples
    got_q.delete(); fd_cnt = 0;
    d_mask = 4'hF; set_samples(16'h1234, 16'hFFFF, 16'h8000, 16'h0001);
    edges(4);
    wait_idle(600);
    chk_bytes("frame_all", 160'h4348301234_434831FFFF_4348328000_4348330001, 20);
    chk("frame_all_done", fd_cnt, 1);

    // sparse mask: ch0 then ch2 only
    got_q.delete(); fd_cnt = 0;
    d_mask = 4'b0101; set_samples(16'h5A5A, 16'h1111, 16'hABCD, 16'h2222);
    edges(4);
    wait_idle(600);
    chk_bytes("frame_sparse", 160'h4348305A5A_434832ABCD, 10);
    chk("frame_sparse_done", fd_cnt, 1);

    // empty mask: nothing sent, nothing counted
    start_cnt = 0;
    d_mask = 4'h0;
    edges(40);
    chk("mask0_starts", start_cnt, 0);
    chk("mask0_overrun", overrun_cnt, 0);

    // random inputs changing every cycle, uart busy 1..10 cycles
    hold_lo = 1; hold_hi = 10;
    repeat (3000) begin
      d_sc   = 1'($urandom_range(0, 1));
      d_mask = 4'($urandom_range(0, 15));
      set_samples(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      step();
    end
    d_sc = 1'b0;
    wait_idle(2000);

    // reset while the third byte is in flight
    hold_lo = 5; hold_hi = 5;
    d_mask = 4'hF; set_samples(16'hCAFE, 16'hBEEF, 16'h0F0F, 16'h7FFF);
    start_cnt = 0; k = 0;
    while (start_cnt < 3 && k < 600) begin
      d_sc = ~d_sc;
      step();
      k++;
    end
    chk("rst_third_byte_seen", start_cnt, 3);
    d_sc = 1'b0;
    repeat (2) step();
    async_reset();
    got_q.delete(); fd_cnt = 0;
    hold_lo = 1; hold_hi = 3;
    d_mask = 4'b0110; set_samples(16'h1357, 16'h0F0F, 16'h7FFF, 16'h2468);
    edges(4);
    wait_idle(600);
    chk_bytes("after_rst", 160'h4348310F0F_4348327FFF, 10);
    chk("after_rst_done", fd_cnt, 1);

    // slow uart: flood with snapshot requests until overrun saturates
    got_q.delete(); fd_cnt = 0;
    hold_lo = 150; hold_hi = 150;
    d_mask = 4'hF; set_samples(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    k = 0;
    while (fd_cnt == 0 && k < 8000) begin
      d_sc = ~d_sc;
      step();
      k++;
    end
    chk("sat_overrun", overrun_cnt, 255);
    chk_bytes("sat_frame", 160'h4348300102_4348310304_4348320506_4348330708, 20);
    d_sc = 1'b0;
    hold_lo = 1; hold_hi = 2;
    wait_idle(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
